// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial frame deserialiser.
//   state_e        : receiver FSM state (hunt for sync, payload, parity)
//   DEF_DATA_W     : default payload width in bits
//   DEF_SYNC_W     : default sync pattern length
//   DEF_SYNC_PAT   : default sync pattern, first-received bit in MSB
package serial_pkg;

    typedef enum logic [1:0] {
        StHunt   = 2'd0,
        StData   = 2'd1,
        StParity = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_SYNC_W = 4;
    localparam logic [DEF_SYNC_W-1:0] DEF_SYNC_PAT = 4'b1011;

endpackage

// File: rtl/sync_window_det.sv
// Sliding-window sync detector.
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset, clears the window
//   clr    : synchronous clear of the window
//   bit_in : serial bit to shift in
//   en     : shift bit_in into the window this cycle
//   match  : window including the current bit equals SYNC_PAT (only while en)
module sync_window_det
    import serial_pkg::*;
#(
    parameter int unsigned          SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0]    SYNC_PAT = DEF_SYNC_PAT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic bit_in,
    input  logic en,
    output logic match
);

    logic [SYNC_W-1:0] window_q;
    logic [SYNC_W-1:0] window_next;

    // Newest bit enters at the LSB so the oldest bit lines up with the pattern MSB.
    assign window_next = {window_q[SYNC_W-2:0], bit_in};
    assign match       = en && (window_next == SYNC_PAT);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            window_q <= '0;
        end else if (en) begin
            window_q <= window_next;
        end
    end

endmodule

// File: rtl/serial_frame_deser.sv
// Serial frame deserialiser: hunts for a sync pattern, collects DATA_W payload
// bits MSB-first, checks an even-parity bit and presents the word on a
// valid/ready output register.
//   clk, rst    : clock (rising edge), synchronous active-high reset
//   sd_in       : serial data bit, sampled only when sd_valid is high
//   sd_valid    : qualifies sd_in
//   word_data   : received payload, first-received bit in MSB
//   word_valid  : word_data holds an unconsumed word
//   word_ready  : consumer accepts word_data when word_valid is high
//   parity_err  : one-cycle pulse, frame discarded on bad parity
//   overrun     : one-cycle pulse, good frame discarded because output was full
module serial_frame_deser
    import serial_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       SYNC_W   = DEF_SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_PAT = DEF_SYNC_PAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sd_in,
    input  logic              sd_valid,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              parity_err,
    output logic              overrun
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   payload_q, payload_d;
    logic                par_q, par_d;
    logic [DATA_W-1:0]   word_data_q, word_data_d;
    logic                word_valid_q, word_valid_d;
    logic                parity_err_q, overrun_q;

    logic sync_match;
    logic hunt_en;
    logic win_clr;
    logic last_data;
    logic out_free;
    logic load;
    logic ovf;
    logic perr;

    assign hunt_en   = sd_valid && (state_q == StHunt);
    // Leaving PARITY always returns to a clean window, good frame or not.
    assign win_clr   = sd_valid && (state_q == StParity);
    assign last_data = (cnt_q == CNT_W'(DATA_W - 1));
    assign out_free  = !word_valid_q || word_ready;

    sync_window_det #(
        .SYNC_W   (SYNC_W),
        .SYNC_PAT (SYNC_PAT)
    ) u_sync (
        .clk    (clk),
        .rst    (rst),
        .clr    (win_clr),
        .bit_in (sd_in),
        .en     (hunt_en),
        .match  (sync_match)
    );

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StHunt;
            cnt_q        <= '0;
            payload_q    <= '0;
            par_q        <= 1'b0;
            word_data_q  <= '0;
            word_valid_q <= 1'b0;
            parity_err_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            payload_q    <= payload_d;
            par_q        <= par_d;
            word_data_q  <= word_data_d;
            word_valid_q <= word_valid_d;
            parity_err_q <= perr;
            overrun_q    <= ovf;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (sd_valid) begin
            unique case (state_q)
                StHunt:   if (sync_match) state_d = StData;
                StData:   if (last_data)  state_d = StParity;
                StParity: state_d = StHunt;
                default:  state_d = StHunt;
            endcase
        end
    end

    // Datapath and output decode.
    always_comb begin
        cnt_d     = cnt_q;
        payload_d = payload_q;
        par_d     = par_q;
        load      = 1'b0;
        ovf       = 1'b0;
        perr      = 1'b0;
        if (sd_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (sync_match) begin
                        cnt_d = '0;
                        par_d = 1'b0;
                    end
                end
                StData: begin
                    payload_d = {payload_q[DATA_W-2:0], sd_in};
                    par_d     = par_q ^ sd_in;
                    cnt_d     = cnt_q + 1'b1;
                end
                StParity: begin
                    // Running XOR of payload plus parity bit must be 0 for even parity.
                    if (par_q ^ sd_in) begin
                        perr = 1'b1;
                    end else if (out_free) begin
                        load = 1'b1;
                    end else begin
                        ovf = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        word_data_d  = load ? payload_q : word_data_q;
        // A load wins over a same-cycle handshake so valid stays high.
        if (load) begin
            word_valid_d = 1'b1;
        end else if (word_valid_q && word_ready) begin
            word_valid_d = 1'b0;
        end else begin
            word_valid_d = word_valid_q;
        end
    end

    assign word_data  = word_data_q;
    assign word_valid = word_valid_q;
    assign parity_err = parity_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_serial_frame_deser.sv
module tb_serial_frame_deser;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned SYNC_W = 4;

    logic             clk;
    logic             rst;
    logic             sd_in;
    logic             sd_valid;
    logic [DATA_W-1:0] word_data;
    logic             word_valid;
    logic             word_ready;
    logic             parity_err;
    logic             overrun;

    int checks;
    int failures;

    serial_frame_deser dut (
        .clk        (clk),
        .rst        (rst),
        .sd_in      (sd_in),
        .sd_valid   (sd_valid),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (frame level) ----------------
    logic [SYNC_W-1:0] pat;
    bit                model_live;
    bit                synced;
    logic              hist[$];
    logic              pay[$];
    logic [DATA_W-1:0] exp_data;
    logic              exp_valid;
    logic              exp_perr;
    logic              exp_ovr;

    initial begin
        pat        = 4'b1011;
        model_live = 0;
    end

    always @(posedge clk) begin
        logic              hs;
        logic              loaded;
        logic [DATA_W-1:0] val;
        int                ones;
        bit                hit;
        exp_perr = 1'b0;
        exp_ovr  = 1'b0;
        if (rst) begin
            model_live = 1;
            synced     = 0;
            hist.delete();
            pay.delete();
            exp_data   = '0;
            exp_valid  = 1'b0;
        end else if (model_live) begin
            hs     = exp_valid && word_ready;
            loaded = 1'b0;
            if (sd_valid) begin
                if (!synced) begin
                    hist.push_back(sd_in);
                    if (hist.size() > SYNC_W) void'(hist.pop_front());
                    if (hist.size() == SYNC_W) begin
                        hit = 1;
                        for (int i = 0; i < int'(SYNC_W); i++)
                            if (hist[i] !== pat[SYNC_W-1-i]) hit = 0;
                        if (hit) begin
                            synced = 1;
                            pay.delete();
                        end
                    end
                end else if (pay.size() < DATA_W) begin
                    pay.push_back(sd_in);
                end else begin
                    val  = '0;
                    ones = int'(sd_in);
                    for (int i = 0; i < int'(DATA_W); i++) begin
                        val  = {val[DATA_W-2:0], pay[i]};
                        ones += int'(pay[i]);
                    end
                    if ((ones % 2) == 0) begin
                        if (!exp_valid || word_ready) begin
                            exp_data = val;
                            loaded   = 1'b1;
                        end else begin
                            exp_ovr = 1'b1;
                        end
                    end else begin
                        exp_perr = 1'b1;
                    end
                    synced = 0;
                    hist.delete();
                    pay.delete();
                end
            end
            if (loaded) exp_valid = 1'b1;
            else if (hs) exp_valid = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("word_valid", 32'(word_valid), 32'(exp_valid));
            check("word_data",  32'(word_data),  32'(exp_data));
            check("parity_err", 32'(parity_err), 32'(exp_perr));
            check("overrun",    32'(overrun),    32'(exp_ovr));
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        @(negedge clk);
        sd_valid = 1'b0;
    endtask

    task automatic send(input logic b);
        @(negedge clk);
        sd_valid = 1'b1;
        sd_in    = b;
    endtask

    task automatic send_sync_data(input logic [DATA_W-1:0] d, input int nbits);
        logic [SYNC_W-1:0] p;
        p = 4'b1011;
        for (int i = SYNC_W - 1; i >= 0; i--) send(p[i]);
        for (int i = 0; i < nbits; i++) send(d[DATA_W-1-i]);
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par);
        send_sync_data(d, DATA_W);
        send(par);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        rst        = 1'b1;
        sd_in      = 1'b0;
        sd_valid   = 1'b0;
        word_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst word_data",  32'(word_data),  32'h0);
        check("rst word_valid", 32'(word_valid), 32'h0);
        check("rst parity_err", 32'(parity_err), 32'h0);
        check("rst overrun",    32'(overrun),    32'h0);
        rst = 1'b0;

        // Basic frame with ready held high.
        word_ready = 1'b1;
        send_frame(8'hA5, 1'b0);
        idle();
        check("a5 data",  32'(word_data),  32'hA5);
        check("a5 valid", 32'(word_valid), 32'h1);
        idle();
        check("a5 drained", 32'(word_valid), 32'h0);

        // Bad parity, then a good frame proves the FSM is hunting again.
        send_frame(8'hA5, 1'b1);
        idle();
        check("perr pulse", 32'(parity_err), 32'h1);
        check("perr valid", 32'(word_valid), 32'h0);
        idle();
        check("perr one cycle", 32'(parity_err), 32'h0);
        send_frame(8'h3C, 1'b0);
        idle();
        check("after perr data",  32'(word_data),  32'h3C);
        check("after perr valid", 32'(word_valid), 32'h1);
        idle();

        // Overrun with the consumer stalled.
        word_ready = 1'b0;
        send_frame(8'hA5, 1'b0);
        idle();
        check("ovr first valid", 32'(word_valid), 32'h1);
        send_frame(8'h3C, 1'b0);
        idle();
        check("ovr pulse", 32'(overrun),    32'h1);
        check("ovr data",  32'(word_data),  32'hA5);
        check("ovr valid", 32'(word_valid), 32'h1);
        idle();
        check("ovr one cycle", 32'(overrun), 32'h0);

        // Handshake in the same cycle as the parity sample.
        send_sync_data(8'h3C, DATA_W);
        @(negedge clk);
        sd_valid   = 1'b1;
        sd_in      = 1'b0;
        word_ready = 1'b1;
        @(negedge clk);
        sd_valid   = 1'b0;
        word_ready = 1'b0;
        check("swap data",  32'(word_data),  32'h3C);
        check("swap valid", 32'(word_valid), 32'h1);
        check("swap no ovr", 32'(overrun),   32'h0);
        word_ready = 1'b1;
        idle();
        idle();
        check("swap drained", 32'(word_valid), 32'h0);

        // Overlapping sync with gaps between bits.
        begin
            logic [5:0] seq;
            seq = 6'b101011;
            for (int i = 5; i >= 0; i--) begin
                send(seq[i]);
                if (i != 0) repeat (3) idle();
            end
        end
        for (int i = 0; i < int'(DATA_W); i++) send(1'b1);
        send(1'b0);
        idle();
        check("gap data",  32'(word_data),  32'hFF);
        check("gap valid", 32'(word_valid), 32'h1);

        // Reset in the middle of a frame with a word still pending.
        word_ready = 1'b0;
        send_sync_data(8'hE0, 3);
        @(negedge clk);
        rst      = 1'b1;
        sd_valid = 1'b1;
        sd_in    = 1'b1;
        @(negedge clk);
        check("midrst data",  32'(word_data),  32'h0);
        check("midrst valid", 32'(word_valid), 32'h0);
        check("midrst perr",  32'(parity_err), 32'h0);
        check("midrst ovr",   32'(overrun),    32'h0);
        rst        = 1'b0;
        sd_valid   = 1'b0;
        word_ready = 1'b1;
        send_frame(8'h01, 1'b1);
        idle();
        check("post rst data",  32'(word_data),  32'h01);
        check("post rst valid", 32'(word_valid), 32'h1);
        idle();

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 599) == 0);
            sd_valid   = ($urandom_range(0, 9) < 7);
            sd_in      = ($urandom_range(0, 1) == 1);
            word_ready = ($urandom_range(0, 2) != 0);
        end
        @(negedge clk);
        rst      = 1'b0;
        sd_valid = 1'b0;
        repeat (2) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
